// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: command encodings, opcodes,
// instruction modes, condition codes and the decode/condition helpers.
package id_pkg;

  // ALU command encodings seen by EXE
  localparam logic [3:0] ExeNop = 4'b0000;
  localparam logic [3:0] ExeMov = 4'b0001;
  localparam logic [3:0] ExeAdd = 4'b0010;
  localparam logic [3:0] ExeAdc = 4'b0011;
  localparam logic [3:0] ExeSub = 4'b0100;
  localparam logic [3:0] ExeSbc = 4'b0101;
  localparam logic [3:0] ExeAnd = 4'b0110;
  localparam logic [3:0] ExeOrr = 4'b0111;
  localparam logic [3:0] ExeEor = 4'b1000;
  localparam logic [3:0] ExeMvn = 4'b1001;

  // Data-processing opcodes, instruction[24:21]
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpMvn = 4'b1111;

  typedef enum logic [1:0] {
    ModeDp  = 2'b00,
    ModeMem = 2'b01,
    ModeBr  = 2'b10,
    ModeRsv = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    CondEq = 4'h0, CondNe = 4'h1, CondCs = 4'h2, CondCc = 4'h3,
    CondMi = 4'h4, CondPl = 4'h5, CondVs = 4'h6, CondVc = 4'h7,
    CondHi = 4'h8, CondLs = 4'h9, CondGe = 4'hA, CondLt = 4'hB,
    CondGt = 4'hC, CondLe = 4'hD, CondAl = 4'hE, CondNv = 4'hF
  } cond_e;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r;
    logic       mem_w;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  // Raw control decode, independent of the condition field.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (mode_e'(instr[27:26]))
      ModeDp: begin
        case (instr[24:21])
          OpMov: begin c.exe_cmd = ExeMov; c.wb_en = 1'b1; end
          OpMvn: begin c.exe_cmd = ExeMvn; c.wb_en = 1'b1; end
          OpAdd: begin c.exe_cmd = ExeAdd; c.wb_en = 1'b1; end
          OpAdc: begin c.exe_cmd = ExeAdc; c.wb_en = 1'b1; end
          OpSub: begin c.exe_cmd = ExeSub; c.wb_en = 1'b1; end
          OpSbc: begin c.exe_cmd = ExeSbc; c.wb_en = 1'b1; end
          OpAnd: begin c.exe_cmd = ExeAnd; c.wb_en = 1'b1; end
          OpOrr: begin c.exe_cmd = ExeOrr; c.wb_en = 1'b1; end
          OpEor: begin c.exe_cmd = ExeEor; c.wb_en = 1'b1; end
          OpCmp: c.exe_cmd = ExeSub;
          OpTst: c.exe_cmd = ExeAnd;
          default: c = '0;
        endcase
        // Every legal opcode has a non-zero command; unknown ones stay all-zero
        if (c.exe_cmd != ExeNop) c.s = instr[20];
      end
      ModeMem: begin
        c.exe_cmd = ExeAdd;
        if (instr[20]) begin
          c.mem_r = 1'b1;
          c.wb_en = 1'b1;
        end else begin
          c.mem_w = 1'b1;
        end
      end
      ModeBr:  c.b = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic z, input logic c,
                                     input logic n, input logic v);
    logic p;
    case (cond_e'(cond))
      CondEq:  p = z;
      CondNe:  p = !z;
      CondCs:  p = c;
      CondCc:  p = !c;
      CondMi:  p = n;
      CondPl:  p = !n;
      CondVs:  p = v;
      CondVc:  p = !v;
      CondHi:  p = c & !z;
      CondLs:  p = !c | z;
      CondGe:  p = (n == v);
      CondLt:  p = (n != v);
      CondGt:  p = !z & (n == v);
      CondLe:  p = z | (n != v);
      CondAl:  p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Register file with two read ports, one write port and optional
// same-cycle write-back forwarding. Out-of-range indices read as zero.
module reg_file_bypass #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [3:0]        raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [REG_CNT];
  logic              in_range1;
  logic              in_range2;

  assign in_range1 = ({28'b0, raddr1} < REG_CNT);
  assign in_range2 = ({28'b0, raddr2} < REG_CNT);

  // Storage update: clear on reset, writes to unimplemented indices are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < REG_CNT; i++) begin
        if (waddr == 4'(i)) regs[i] <= wdata;
      end
    end
  end

  // Read ports with optional forwarding of the write happening this cycle
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    for (int unsigned i = 0; i < REG_CNT; i++) begin
      if (raddr1 == 4'(i)) rdata1 = regs[i];
      if (raddr2 == 4'(i)) rdata2 = regs[i];
    end
    if (BYPASS && we && in_range1 && (raddr1 == waddr)) rdata1 = wdata;
    if (BYPASS && we && in_range2 && (raddr2 == waddr)) rdata2 = wdata;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with built-in ID/EX register: decodes, condition-checks,
// reads operands and registers everything for EXE; bubbles on freeze/flush.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc,
  input  logic              z,
  input  logic              c,
  input  logic              n,
  input  logic              v,
  input  logic              freeze,
  input  logic              flush,
  input  logic              wb_wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic              out_valid,
  output logic              wb_en,
  output logic              mem_r,
  output logic              mem_w,
  output logic              b,
  output logic              s,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic [3:0]        dest,
  output logic              imm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src
);

  ctrl_t             ctrl_raw;
  ctrl_t             ctrl_live;
  ctrl_t             ctrl_q;
  logic              live;
  logic              is_str;
  logic [DATA_W-1:0] rn_data;
  logic [DATA_W-1:0] rm_data;

  // Decode and hazard indices; hazards use the raw decode, not the condition result
  always_comb begin
    ctrl_raw  = decode(instruction);
    is_str    = (instruction[27:26] == ModeMem) && !instruction[20];
    live      = in_valid && cond_pass(instruction[31:28], z, c, n, v);
    ctrl_live = live ? ctrl_raw : '0;
    src1      = instruction[19:16];
    src2      = is_str ? instruction[15:12] : instruction[3:0];
    two_src   = (!instruction[25] && (instruction[27:26] == ModeDp)) || is_str;
  end

  reg_file_bypass #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT),
    .BYPASS (BYPASS)
  ) u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_wb_en),
    .waddr (wb_dest),
    .wdata (wb_value),
    .raddr1(src1),
    .rdata1(rn_data),
    .raddr2(src2),
    .rdata2(rm_data)
  );

  // ID/EX register: reset > flush > freeze > capture; bubbles keep data fields
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      ctrl_q        <= '0;
      pc_out        <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      dest          <= '0;
      imm           <= 1'b0;
      shift_operand <= '0;
      signed_imm    <= '0;
    end else if (flush || freeze) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      out_valid     <= live;
      ctrl_q        <= ctrl_live;
      pc_out        <= pc;
      val_rn        <= rn_data;
      val_rm        <= rm_data;
      dest          <= instruction[15:12];
      imm           <= instruction[25];
      shift_operand <= instruction[11:0];
      signed_imm    <= instruction[23:0];
    end
  end

  assign wb_en   = ctrl_q.wb_en;
  assign mem_r   = ctrl_q.mem_r;
  assign mem_w   = ctrl_q.mem_w;
  assign b       = ctrl_q.b;
  assign s       = ctrl_q.s;
  assign exe_cmd = ctrl_q.exe_cmd;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: three instances (default, no bypass,
// 8 registers) share stimulus; expectations are queued per instance.
module tb_id_stage_pipe;

  typedef struct packed {
    logic        chk_data;
    logic        valid;
    logic [8:0]  ctrl;   // {wb_en, mem_r, mem_w, b, s, exe_cmd}
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic        imm;
    logic [23:0] simm;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two;
  } hz_t;

  localparam logic [8:0] C_NONE = 9'b0;
  localparam logic [8:0] C_ADD  = {5'b10000, 4'b0010};
  localparam logic [8:0] C_MOV  = {5'b10000, 4'b0001};
  localparam logic [8:0] C_STR  = {5'b00100, 4'b0010};
  localparam logic [8:0] C_LDR  = {5'b11000, 4'b0010};
  localparam logic [8:0] C_CMP  = {5'b00001, 4'b0100};
  localparam logic [8:0] C_B    = {5'b00010, 4'b0000};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        z, c, n, v;
  logic        freeze, flush;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;

  logic        out_valid_w [3];
  logic        wb_en_w [3], mem_r_w [3], mem_w_w [3], b_w [3], s_w [3];
  logic [3:0]  exe_cmd_w [3];
  logic [31:0] pc_out_w [3], val_rn_w [3], val_rm_w [3];
  logic [3:0]  dest_w [3];
  logic        imm_w [3];
  logic [11:0] shop_w [3];
  logic [23:0] simm_w [3];
  logic [3:0]  src1_w [3], src2_w [3];
  logic        two_src_w [3];

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  hz_t  hq[$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    id_stage_pipe #(
      .DATA_W (32),
      .REG_CNT((k == 2) ? 8 : 16),
      .BYPASS ((k == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .instruction  (instruction),
      .pc           (pc),
      .z            (z),
      .c            (c),
      .n            (n),
      .v            (v),
      .freeze       (freeze),
      .flush        (flush),
      .wb_wb_en     (wb_wb_en),
      .wb_dest      (wb_dest),
      .wb_value     (wb_value),
      .out_valid    (out_valid_w[k]),
      .wb_en        (wb_en_w[k]),
      .mem_r        (mem_r_w[k]),
      .mem_w        (mem_w_w[k]),
      .b            (b_w[k]),
      .s            (s_w[k]),
      .exe_cmd      (exe_cmd_w[k]),
      .pc_out       (pc_out_w[k]),
      .val_rn       (val_rn_w[k]),
      .val_rm       (val_rm_w[k]),
      .dest         (dest_w[k]),
      .imm          (imm_w[k]),
      .shift_operand(shop_w[k]),
      .signed_imm   (simm_w[k]),
      .src1         (src1_w[k]),
      .src2         (src2_w[k]),
      .two_src      (two_src_w[k])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int k, input exp_t e);
    logic [8:0] ctrl;
    ctrl = {wb_en_w[k], mem_r_w[k], mem_w_w[k], b_w[k], s_w[k], exe_cmd_w[k]};
    chk($sformatf("dut%0d out_valid", k), 32'(out_valid_w[k]), 32'(e.valid));
    chk($sformatf("dut%0d ctrl", k), 32'(ctrl), 32'(e.ctrl));
    if (e.chk_data) begin
      chk($sformatf("dut%0d pc_out", k), pc_out_w[k], e.pc);
      chk($sformatf("dut%0d val_rn", k), val_rn_w[k], e.rn);
      chk($sformatf("dut%0d val_rm", k), val_rm_w[k], e.rm);
      chk($sformatf("dut%0d dest", k), 32'(dest_w[k]), 32'(e.dest));
      chk($sformatf("dut%0d imm", k), 32'(imm_w[k]), 32'(e.imm));
      chk($sformatf("dut%0d signed_imm", k), 32'(simm_w[k]), 32'(e.simm));
      chk($sformatf("dut%0d shift_operand", k), 32'(shop_w[k]), 32'(e.simm[11:0]));
    end
  endtask

  // Monitor: registered outputs and hazard indices checked mid-cycle
  always @(negedge clk) begin
    hz_t  h;
    exp_t e;
    if (hq.size() > 0) begin
      h = hq.pop_front();
      if (h.en) begin
        chk("src1", 32'(src1_w[0]), 32'(h.src1));
        chk("src2", 32'(src2_w[0]), 32'(h.src2));
        chk("two_src", 32'(two_src_w[0]), 32'(h.two));
      end
    end
    if (q0.size() > 0) begin e = q0.pop_front(); cmp_dut(0, e); end
    if (q1.size() > 0) begin e = q1.pop_front(); cmp_dut(1, e); end
    if (q2.size() > 0) begin e = q2.pop_front(); cmp_dut(2, e); end
  end

  function automatic exp_t ex(input logic vl, input logic [8:0] ct, input logic [31:0] p,
                              input logic [31:0] rn, input logic [31:0] rm,
                              input logic [3:0] d, input logic im, input logic [23:0] si);
    exp_t e;
    e = '{chk_data: 1'b1, valid: vl, ctrl: ct, pc: p, rn: rn, rm: rm, dest: d, imm: im,
          simm: si};
    return e;
  endfunction

  function automatic exp_t exc(input logic vl, input logic [8:0] ct);
    exp_t e;
    e = '0;
    e.valid = vl;
    e.ctrl  = ct;
    return e;
  endfunction

  function automatic hz_t hz(input logic [3:0] a, input logic [3:0] bb, input logic t);
    hz_t h;
    h = '{en: 1'b1, src1: a, src2: bb, two: t};
    return h;
  endfunction

  // Inputs are driven 1 time unit after posedge; registered expectation queued at the edge
  task automatic issue3(input hz_t h, input exp_t e0, input exp_t e1, input exp_t e2);
    hq.push_back(h);
    @(posedge clk);
    q0.push_back(e0);
    q1.push_back(e1);
    q2.push_back(e2);
    #1;
  endtask

  task automatic issue(input hz_t h, input exp_t e);
    issue3(h, e, e, e);
  endtask

  task automatic drv(input logic vl, input logic [31:0] ins, input logic [31:0] p);
    in_valid    = vl;
    instruction = ins;
    pc          = p;
    freeze      = 1'b0;
    flush       = 1'b0;
    wb_wb_en    = 1'b0;
    wb_dest     = 4'd0;
    wb_value    = 32'd0;
  endtask

  task automatic wb(input logic [3:0] d, input logic [31:0] val);
    wb_wb_en = 1'b1;
    wb_dest  = d;
    wb_value = val;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t zero;
    hz_t  hn;
    zero = ex(1'b0, C_NONE, 0, 0, 0, 4'd0, 1'b0, 24'd0);
    hn   = '0;
    rst = 1'b1;
    {z, c, n, v} = 4'b0;
    drv(1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;

    // Reset state
    issue(hn, zero);
    rst = 1'b0;
    // Preload R2=5, R3=7
    drv(1'b0, 32'd0, 32'd0); wb(4'd2, 32'd5); issue(hn, exc(1'b0, C_NONE));
    drv(1'b0, 32'd0, 32'd0); wb(4'd3, 32'd7); issue(hn, exc(1'b0, C_NONE));
    // ADD R1,R2,R3
    drv(1'b1, 32'hE082_1003, 32'h100);
    issue(hz(4'd2, 4'd3, 1'b1), ex(1'b1, C_ADD, 32'h100, 5, 7, 4'd1, 1'b0, 24'h821003));
    // MOVNE R0,#1 with z=1 fails; preload R4
    drv(1'b1, 32'h13A0_0001, 32'h104); z = 1'b1; wb(4'd4, 32'hAB);
    issue(hz(4'd0, 4'd1, 1'b0), ex(1'b0, C_NONE, 32'h104, 0, 0, 4'd0, 1'b1, 24'hA00001));
    // MOVNE with z=0 passes; preload R5
    drv(1'b1, 32'h13A0_0001, 32'h108); z = 1'b0; wb(4'd5, 32'h40);
    issue(hz(4'd0, 4'd1, 1'b0), ex(1'b1, C_MOV, 32'h108, 0, 0, 4'd0, 1'b1, 24'hA00001));
    // STR R4,[R5]
    drv(1'b1, 32'hE585_4000, 32'h10C);
    issue(hz(4'd5, 4'd4, 1'b1), ex(1'b1, C_STR, 32'h10C, 32'h40, 32'hAB, 4'd4, 1'b0, 24'h854000));
    // ADD R6,R2,R3 while R2 is written with 0x55
    drv(1'b1, 32'hE082_6003, 32'h110); wb(4'd2, 32'h55);
    issue3(hz(4'd2, 4'd3, 1'b1),
           ex(1'b1, C_ADD, 32'h110, 32'h55, 7, 4'd6, 1'b0, 24'h826003),
           ex(1'b1, C_ADD, 32'h110, 32'h5, 7, 4'd6, 1'b0, 24'h826003),
           ex(1'b1, C_ADD, 32'h110, 32'h55, 7, 4'd6, 1'b0, 24'h826003));
    // LDR R7,[R2] under freeze: bubble, data fields hold
    drv(1'b1, 32'hE592_7000, 32'h114); freeze = 1'b1;
    issue3(hz(4'd2, 4'd0, 1'b0),
           ex(1'b0, C_NONE, 32'h110, 32'h55, 7, 4'd6, 1'b0, 24'h826003),
           ex(1'b0, C_NONE, 32'h110, 32'h5, 7, 4'd6, 1'b0, 24'h826003),
           ex(1'b0, C_NONE, 32'h110, 32'h55, 7, 4'd6, 1'b0, 24'h826003));
    // Freeze released, same LDR
    drv(1'b1, 32'hE592_7000, 32'h114);
    issue(hz(4'd2, 4'd0, 1'b0), ex(1'b1, C_LDR, 32'h114, 32'h55, 0, 4'd7, 1'b0, 24'h927000));
    // Freeze and flush together, then flush alone
    drv(1'b1, 32'hE082_1003, 32'h118); freeze = 1'b1; flush = 1'b1;
    issue(hz(4'd2, 4'd3, 1'b1), ex(1'b0, C_NONE, 32'h114, 32'h55, 0, 4'd7, 1'b0, 24'h927000));
    drv(1'b1, 32'hE082_1003, 32'h11C); flush = 1'b1;
    issue(hz(4'd2, 4'd3, 1'b1), ex(1'b0, C_NONE, 32'h114, 32'h55, 0, 4'd7, 1'b0, 24'h927000));
    // CMPS R2,R3
    drv(1'b1, 32'hE152_0003, 32'h120);
    issue(hz(4'd2, 4'd3, 1'b1), ex(1'b1, C_CMP, 32'h120, 32'h55, 7, 4'd0, 1'b0, 24'h520003));
    // MOVGT fails and MOVLT passes with n=1, v=0
    drv(1'b1, 32'hC3A0_0001, 32'h124); n = 1'b1;
    issue(hz(4'd0, 4'd1, 1'b0), exc(1'b0, C_NONE));
    drv(1'b1, 32'hB3A0_0001, 32'h128);
    issue(hz(4'd0, 4'd1, 1'b0), ex(1'b1, C_MOV, 32'h128, 0, 0, 4'd0, 1'b1, 24'hA00001));
    // Branch
    drv(1'b1, 32'hEA00_0010, 32'h12C); n = 1'b0;
    issue(hz(4'd0, 4'd0, 1'b0), ex(1'b1, C_B, 32'h12C, 0, 0, 4'd0, 1'b1, 24'h000010));
    // Write R12, then read it: ignored on the 8-register instance
    drv(1'b0, 32'd0, 32'd0); wb(4'd12, 32'h99);
    issue(hn, exc(1'b0, C_NONE));
    drv(1'b1, 32'hE08C_100C, 32'h130);
    issue3(hz(4'd12, 4'd12, 1'b1),
           ex(1'b1, C_ADD, 32'h130, 32'h99, 32'h99, 4'd1, 1'b0, 24'h8C100C),
           ex(1'b1, C_ADD, 32'h130, 32'h99, 32'h99, 4'd1, 1'b0, 24'h8C100C),
           ex(1'b1, C_ADD, 32'h130, 0, 0, 4'd1, 1'b0, 24'h8C100C));
    // Write R1, then reset mid-stream with a live instruction presented
    drv(1'b0, 32'd0, 32'd0); wb(4'd1, 32'h11);
    issue(hn, exc(1'b0, C_NONE));
    drv(1'b1, 32'hE082_1003, 32'h134); rst = 1'b1;
    issue(hz(4'd2, 4'd3, 1'b1), zero);
    rst = 1'b0;
    // ADD R6,R1,R1 after reset: R1 cleared
    drv(1'b1, 32'hE081_6001, 32'h138);
    issue(hz(4'd1, 4'd1, 1'b1), ex(1'b1, C_ADD, 32'h138, 0, 0, 4'd6, 1'b0, 24'h816001));
    drv(1'b0, 32'd0, 32'd0);
    issue(hn, exc(1'b0, C_NONE));

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", 32'(q0.size() + q1.size() + q2.size() + hq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
